load_store_unit: RTL and testbench

//  Multi-cycle data-memory access stage downstream of control decode. Consumes decoded
//  mem_write / data_size / extension_type, ALU address and rs2 data. Performs one

---
 rtl/riscv_pkg.sv | 18 +
 rtl/lsu_align.sv | 47 ++++
 rtl/load_store_unit.sv | 138 +++++++++++++
 tb/tb_load_store_unit.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared decode constants and LSU state encoding.
package riscv_pkg;

  localparam logic [1:0] DS_BYTE = 2'b00;
  localparam logic [1:0] DS_HALF = 2'b01;
  localparam logic [1:0] DS_WORD = 2'b10;

  localparam logic EXT_SIGN = 1'b0;
  localparam logic EXT_ZERO = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    RESP = 2'b10,
    DONE = 2'b11
  } lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for stores and lane extract/extend for loads.
module lsu_align
  import riscv_pkg::*;
(
  input  logic [1:0]  st_size_i,
  input  logic [1:0]  st_addr_lo_i,
  input  logic [31:0] st_wdata_i,
  output logic [3:0]  st_be_o,
  output logic [31:0] st_wdata_o,
  input  logic [1:0]  ld_size_i,
  input  logic        ld_ext_i,
  input  logic [1:0]  ld_addr_lo_i,
  input  logic [31:0] ld_rdata_i,
  output logic [31:0] ld_data_o
);

  logic [31:0] lane;

  always_comb begin
    st_be_o    = 4'b1111;
    st_wdata_o = st_wdata_i;
    case (st_size_i)
      DS_BYTE: begin
        st_be_o    = 4'b0001 << st_addr_lo_i;
        st_wdata_o = {4{st_wdata_i[7:0]}};
      end
      DS_HALF: begin
        st_be_o    = 4'b0011 << {st_addr_lo_i[1], 1'b0};
        st_wdata_o = {2{st_wdata_i[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    lane      = ld_rdata_i >> {ld_addr_lo_i, 3'b000};
    ld_data_o = lane;
    case (ld_size_i)
      DS_BYTE: ld_data_o = (ld_ext_i == EXT_ZERO) ? {24'h0, lane[7:0]}
                                                  : {{24{lane[7]}}, lane[7:0]};
      DS_HALF: ld_data_o = (ld_ext_i == EXT_ZERO) ? {16'h0, lane[15:0]}
                                                  : {{16{lane[15]}}, lane[15:0]};
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle load/store stage: one valid/ready bus transaction per access, with timeout.
module load_store_unit
  import riscv_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        lsu_req,
  input  logic        mem_write,
  input  logic [1:0]  data_size,
  input  logic        extension_type,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata_out,
  output logic        stall,
  output logic        done,
  output logic        err,
  output logic        misaligned,
  output logic        bus_valid,
  input  logic        bus_ready,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata
);

  localparam int unsigned CW = $clog2(TIMEOUT) + 1;
  // Abort on the edge where the count would reach TIMEOUT-1, so done lands TIMEOUT-1 cycles after leaving IDLE.
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 2);

  lsu_state_e  state_q;
  logic [CW-1:0] tmo_q;
  logic [1:0]  size_q, lo_q;
  logic        ext_q;
  logic        bus_valid_q, bus_we_q, done_q, err_q;
  logic [31:0] bus_addr_q, bus_wdata_q, rdata_q;
  logic [3:0]  bus_be_q;
  logic        size_bad;
  logic [3:0]  st_be;
  logic [31:0] st_wdata, ld_data;

  lsu_align u_align (
    .st_size_i    (data_size),
    .st_addr_lo_i (addr[1:0]),
    .st_wdata_i   (wdata),
    .st_be_o      (st_be),
    .st_wdata_o   (st_wdata),
    .ld_size_i    (size_q),
    .ld_ext_i     (ext_q),
    .ld_addr_lo_i (lo_q),
    .ld_rdata_i   (bus_rdata),
    .ld_data_o    (ld_data)
  );

  always_comb begin
    size_bad = 1'b1;
    case (data_size)
      DS_BYTE: size_bad = 1'b0;
      DS_HALF: size_bad = addr[0];
      DS_WORD: size_bad = |addr[1:0];
      default: size_bad = 1'b1;
    endcase
  end

  assign misaligned = lsu_req & size_bad;
  assign stall      = lsu_req & ~misaligned & (state_q != DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      tmo_q       <= '0;
      size_q      <= '0;
      lo_q        <= '0;
      ext_q       <= 1'b0;
      bus_valid_q <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_be_q    <= '0;
      bus_wdata_q <= '0;
      rdata_q     <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (lsu_req && !misaligned) begin
            size_q      <= data_size;
            lo_q        <= addr[1:0];
            ext_q       <= extension_type;
            bus_we_q    <= mem_write;
            bus_addr_q  <= {addr[31:2], 2'b00};
            bus_be_q    <= st_be;
            bus_wdata_q <= st_wdata;
            bus_valid_q <= 1'b1;
            tmo_q       <= '0;
            state_q     <= REQ;
          end
        end
        REQ, RESP: begin
          tmo_q <= tmo_q + CW'(1);
          if (tmo_q == TMO_LAST) begin
            bus_valid_q <= 1'b0;
            rdata_q     <= '0;
            done_q      <= 1'b1;
            err_q       <= 1'b1;
            state_q     <= DONE;
          end else if (state_q == REQ) begin
            if (bus_ready) begin
              bus_valid_q <= 1'b0;
              state_q     <= RESP;
            end
          end else if (bus_rvalid) begin
            rdata_q <= bus_we_q ? '0 : ld_data;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rdata_out = rdata_q;
  assign done      = done_q;
  assign err       = err_q;
  assign bus_valid = bus_valid_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_be    = bus_be_q;
  assign bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit.
module tb_load_store_unit;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        lsu_req = 1'b0, mem_write = 1'b0, extension_type = 1'b0;
  logic [1:0]  data_size = 2'b00;
  logic [31:0] addr = '0, wdata = '0;
  logic [31:0] rdata_out, bus_addr, bus_wdata;
  logic        stall, done, err, misaligned, bus_valid, bus_we;
  logic [3:0]  bus_be;
  logic        bus_ready = 1'b0, bus_rvalid = 1'b0;
  logic [31:0] bus_rdata = '0;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  load_store_unit #(.TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .lsu_req(lsu_req), .mem_write(mem_write),
    .data_size(data_size), .extension_type(extension_type), .addr(addr),
    .wdata(wdata), .rdata_out(rdata_out), .stall(stall), .done(done),
    .err(err), .misaligned(misaligned), .bus_valid(bus_valid),
    .bus_ready(bus_ready), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_rvalid(bus_rvalid),
    .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Full handshake: ready after rdly extra REQ cycles, rvalid at first opportunity.
  task automatic access(input string tag, input logic we, input logic [1:0] sz,
                        input logic ext, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] rd, input int unsigned rdly,
                        input logic [3:0] ebe, input logic [31:0] ewd,
                        input logic [31:0] erd);
    lsu_req = 1'b1; mem_write = we; data_size = sz; extension_type = ext;
    addr = a; wdata = wd;
    #1;
    check({tag, " stall_idle"}, 32'(stall), 32'd1);
    check({tag, " misaligned"}, 32'(misaligned), 32'd0);
    tick();
    check({tag, " bus_valid"}, 32'(bus_valid), 32'd1);
    check({tag, " bus_we"}, 32'(bus_we), 32'(we));
    check({tag, " bus_addr"}, bus_addr, {a[31:2], 2'b00});
    check({tag, " bus_be"}, 32'(bus_be), 32'(ebe));
    check({tag, " bus_wdata"}, bus_wdata, ewd);
    for (int unsigned i = 0; i < rdly; i++) begin
      tick();
      check({tag, " valid_held"}, 32'(bus_valid), 32'd1);
      check({tag, " stall_req"}, 32'(stall), 32'd1);
    end
    bus_ready = 1'b1;
    tick();
    bus_ready = 1'b0;
    check({tag, " valid_drop"}, 32'(bus_valid), 32'd0);
    check({tag, " done_early"}, 32'(done), 32'd0);
    check({tag, " stall_resp"}, 32'(stall), 32'd1);
    bus_rvalid = 1'b1; bus_rdata = rd;
    tick();
    bus_rvalid = 1'b0;
    check({tag, " done"}, 32'(done), 32'd1);
    check({tag, " err"}, 32'(err), 32'd0);
    check({tag, " stall_done"}, 32'(stall), 32'd0);
    check({tag, " rdata_out"}, rdata_out, erd);
    lsu_req = 1'b0;
    tick();
    check({tag, " done_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    int unsigned n;
    #3;
    check("rst bus_valid", 32'(bus_valid), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst err", 32'(err), 32'd0);
    check("rst rdata_out", rdata_out, 32'd0);
    check("rst bus_be", 32'(bus_be), 32'd0);
    check("rst stall", 32'(stall), 32'd0);
    #10 rst_n = 1'b1;
    tick();

    access("SW", 1'b1, DS_WORD, 1'b0, 32'h1000_0008, 32'hDEAD_BEEF, 32'h0, 1,
           4'b1111, 32'hDEAD_BEEF, 32'h0);
    access("LB", 1'b0, DS_BYTE, EXT_SIGN, 32'h0000_0003, 32'h0, 32'h8000_0000, 0,
           4'b1000, 32'h0, 32'hFFFF_FF80);
    access("LBU", 1'b0, DS_BYTE, EXT_ZERO, 32'h0000_0003, 32'h0, 32'h8000_0000, 0,
           4'b1000, 32'h0, 32'h0000_0080);
    access("SH", 1'b1, DS_HALF, 1'b0, 32'h0000_0002, 32'h0000_1234, 32'h0, 0,
           4'b1100, 32'h1234_1234, 32'h0);
    access("LH", 1'b0, DS_HALF, EXT_SIGN, 32'h0000_0002, 32'h0, 32'h8001_0000, 0,
           4'b1100, 32'h0, 32'hFFFF_8001);
    access("LHU", 1'b0, DS_HALF, EXT_ZERO, 32'h0000_0100, 32'h0, 32'h1234_F00D, 2,
           4'b0011, 32'h0, 32'h0000_F00D);
    access("LB1", 1'b0, DS_BYTE, EXT_SIGN, 32'h0000_0001, 32'h0, 32'h0000_7F00, 0,
           4'b0010, 32'h0, 32'h0000_007F);
    access("SB", 1'b1, DS_BYTE, 1'b0, 32'h2000_0001, 32'h0000_00AB, 32'h0, 0,
           4'b0010, 32'hABAB_ABAB, 32'h0);
    access("LW", 1'b0, DS_WORD, EXT_ZERO, 32'h0000_0004, 32'h0, 32'hCAFE_BABE, 0,
           4'b1111, 32'h0, 32'hCAFE_BABE);

    // Misaligned / illegal requests never reach the bus.
    lsu_req = 1'b1; mem_write = 1'b0; data_size = DS_WORD; addr = 32'h0000_0006;
    #1;
    check("LW6 misaligned", 32'(misaligned), 32'd1);
    check("LW6 stall", 32'(stall), 32'd0);
    for (int unsigned i = 0; i < 3; i++) begin
      tick();
      check("LW6 no_valid", 32'(bus_valid), 32'd0);
    end
    data_size = 2'b11; addr = 32'h0000_0000;
    #1 check("SZ11 misaligned", 32'(misaligned), 32'd1);
    data_size = DS_HALF; addr = 32'h0000_0001;
    #1 check("LH1 misaligned", 32'(misaligned), 32'd1);
    lsu_req = 1'b0; data_size = 2'b11;
    #1 check("noreq misaligned", 32'(misaligned), 32'd0);

    // Timeout with bus_ready held low.
    tick();
    lsu_req = 1'b1; data_size = DS_WORD; addr = 32'h0000_0020;
    tick();
    check("TMO bus_valid", 32'(bus_valid), 32'd1);
    n = 0;
    while (!done && n < 40) begin
      tick();
      n++;
    end
    check("TMO cycles", n, 32'd15);
    check("TMO err", 32'(err), 32'd1);
    check("TMO rdata_out", rdata_out, 32'd0);
    check("TMO bus_valid_off", 32'(bus_valid), 32'd0);
    lsu_req = 1'b0;
    tick();
    bus_rvalid = 1'b1; bus_rdata = 32'hFFFF_FFFF;
    tick();
    bus_rvalid = 1'b0;
    check("TMO late done", 32'(done), 32'd0);
    check("TMO late rdata", rdata_out, 32'd0);
    tick();

    // Async reset mid-transaction.
    access("LW2", 1'b0, DS_WORD, EXT_SIGN, 32'h0000_0040, 32'h0, 32'h1122_3344, 0,
           4'b1111, 32'h0, 32'h1122_3344);
    lsu_req = 1'b1; data_size = DS_WORD; addr = 32'h0000_0040;
    tick();
    check("RST req valid", 32'(bus_valid), 32'd1);
    rst_n = 1'b0; lsu_req = 1'b0;
    #1;
    check("RST req valid_off", 32'(bus_valid), 32'd0);
    check("RST req rdata", rdata_out, 32'd0);
    check("RST req addr", bus_addr, 32'd0);
    rst_n = 1'b1;
    lsu_req = 1'b1;
    tick();
    bus_ready = 1'b1;
    tick();
    bus_ready = 1'b0;
    check("RST resp stall", 32'(stall), 32'd1);
    rst_n = 1'b0; lsu_req = 1'b0;
    #1;
    check("RST resp valid", 32'(bus_valid), 32'd0);
    check("RST resp stall_off", 32'(stall), 32'd0);
    check("RST resp be", 32'(bus_be), 32'd0);
    #3 rst_n = 1'b1;
    tick();
    bus_rvalid = 1'b1; bus_rdata = 32'h5555_AAAA;
    tick();
    bus_rvalid = 1'b0;
    check("RST stray done", 32'(done), 32'd0);
    check("RST stray rdata", rdata_out, 32'd0);
    check("RST stray valid", 32'(bus_valid), 32'd0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
